// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer and its command FIFO.
//
// Contents:
//   S0..S5       state encodings of the downstream ALU controller (mirrored on dbg_state)
//   OP_ADD/SUB   operation encodings carried in a command and driven onto the bus in LDM
//   CMD_W/cmd_t  command layout {op, a, b}, 9 bits
//   seq_state_e  sequencer states; CAP has no controller state of its own and mirrors S1
//   mirror_state maps a sequencer state to the controller encoding it shadows
package alu_pkg;

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int CMD_W = 9;

    typedef struct packed {
        logic       op;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    typedef enum logic [2:0] {
        ST_RST0 = S0,
        ST_IDLE = S1,
        ST_LDA  = S2,
        ST_LDB  = S3,
        ST_LDM  = S4,
        ST_LDC  = S5,
        ST_CAP  = 3'd6
    } seq_state_e;

    function automatic logic [2:0] mirror_state(input seq_state_e s);
        logic [2:0] enc;
        case (s)
            ST_CAP:  enc = S1;
            default: enc = s;
        endcase
        return enc;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO for the ALU command sequencer.
//
// Parameters:
//   DEPTH     number of entries; 2 or 4 (power of two so the pointers wrap naturally)
// Ports:
//   clk       clock, rising edge
//   reset     asynchronous, active-high; empties the FIFO
//   wr_valid  write offered
//   wr_data   command {op, a, b}
//   wr_ready  FIFO not full
//   rd_pop    remove the head entry
//   rd_data   head entry (valid while !empty)
//   empty     FIFO holds no entries
module cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    input  logic [CMD_W-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_pop,
    output logic [CMD_W-1:0] rd_data,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             push;
    logic             pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign wr_ready = !full;
    // A full FIFO refuses a write even when the head is popped in the same
    // cycle, so cmd_ready never depends on the pop decision.
    assign push     = wr_valid && !full;
    assign pop      = rd_pop && !empty;
    assign rd_data  = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; validity is defined solely by the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// ALU command sequencer. Queues {op, a, b} commands and walks the downstream
// ALU controller through load-A, load-B, load-mode, compute and capture,
// shadowing the controller state in lock-step. The result is returned on a
// valid/ready response port.
//
// Parameters:
//   FIFO_DEPTH  command FIFO entries; 2 or 4
// Ports:
//   clk, reset                 clock (rising edge); async active-high reset, shared with the controller
//   cmd_valid/cmd_ready        command handshake; cmd_op (0 add, 1 sub), cmd_a, cmd_b operands
//   ctl                        advance request to the ALU controller
//   bus_out/bus_oe             operand driven onto the shared bus and its enable (bus_out=0 when !bus_oe)
//   res_in/z_in/cout_in        controller C-register, zero flag and carry flag
//   rsp_valid/rsp_ready        response handshake; rsp_data, rsp_z, rsp_c result and flags
//   busy                       sequence in flight or commands queued
//   dbg_state                  mirrored controller state encoding
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic       ctl,
    output logic [3:0] bus_out,
    output logic       bus_oe,
    input  logic [3:0] res_in,
    input  logic       z_in,
    input  logic       cout_in,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic       rsp_z,
    output logic       rsp_c,
    output logic       busy,
    output logic [2:0] dbg_state
);

    seq_state_e state;
    cmd_t       head;
    logic       fifo_empty;
    logic       pop;
    logic       rsp_free;
    logic       go_rst0;
    logic       go_idle;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (cmd_valid),
        .wr_data  ({cmd_op, cmd_a, cmd_b}),
        .wr_ready (cmd_ready),
        .rd_pop   (pop),
        .rd_data  (head),
        .empty    (fifo_empty)
    );

    // The response register counts as free when empty or being drained this
    // cycle, so back-to-back commands lose no cycle waiting for it.
    assign rsp_free = !rsp_valid || rsp_ready;
    assign go_rst0  = (state == ST_RST0) && !fifo_empty;
    assign go_idle  = (state == ST_IDLE) && !fifo_empty && rsp_free;
    assign pop      = (state == ST_CAP);

    // ctl is a decode rather than a register: in RST0/IDLE it must follow the
    // same-cycle FIFO and response status, and the controller advances on it
    // at the very edge our own state advances, which keeps the mirror exact.
    assign ctl = go_rst0 || go_idle ||
                 (state inside {ST_LDA, ST_LDB, ST_LDM});

    assign busy      = !(state inside {ST_RST0, ST_IDLE}) || !fifo_empty;
    assign dbg_state = mirror_state(state);

    // The bus drive is registered from the next state; the head entry stays
    // put from IDLE until the pop in CAP, so loading it one edge early is safe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RST0;
            bus_oe    <= 1'b0;
            bus_out   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_z     <= 1'b0;
            rsp_c     <= 1'b0;
        end else begin
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

            case (state)
                ST_RST0: begin
                    if (go_rst0) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (go_idle) begin
                        state   <= ST_LDA;
                        bus_oe  <= 1'b1;
                        bus_out <= head.a;
                    end
                end
                ST_LDA: begin
                    state   <= ST_LDB;
                    bus_out <= head.b;
                end
                ST_LDB: begin
                    state   <= ST_LDM;
                    bus_out <= {3'b000, head.op};
                end
                ST_LDM: begin
                    state   <= ST_LDC;
                    bus_oe  <= 1'b0;
                    bus_out <= '0;
                end
                ST_LDC: begin
                    state <= ST_CAP;
                end
                ST_CAP: begin
                    // Entry to CAP required a free response register, so
                    // nothing pending is overwritten here.
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b1;
                    rsp_data  <= res_in;
                    rsp_z     <= z_in;
                    rsp_c     <= cout_in;
                end
                default: begin
                    state <= ST_RST0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, default 2, command FIFO entries; legal values are 2 and 4 only.
REQ-002 SHALL have port: clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: cmd_valid input 1 command offered; cmd_ready output 1 FIFO can accept.
REQ-005 SHALL have ports: cmd_op input 1 (0 add, 1 sub); cmd_a input 4 operand A; cmd_b input 4 operand B.
REQ-006 SHALL have ports: ctl output 1 drives ALU controller ctl; bus_out output 4 operand onto shared bus; bus_oe output 1 bus drive enable.
REQ-007 SHALL have ports: res_in input 4 C-register value; z_in input 1 zero flag; cout_in input 1 carry flag.
REQ-008 SHALL have ports: rsp_valid output 1; rsp_ready input 1; rsp_data output 4; rsp_z output 1; rsp_c output 1.
REQ-009 SHALL have ports: busy output 1 (state not IDLE/RST0 or FIFO non-empty); dbg_state output 3 mirrored controller state.

Function
REQ-010 SHALL track the downstream controller in lock-step; states RST0(mirror S0), IDLE(S1), LDA(S2), LDB(S3), LDM(S4), LDC(S5), CAP(S1).
REQ-011 SHALL implement a FIFO_DEPTH-entry command FIFO of {op,a,b}; push when cmd_valid & cmd_ready; cmd_ready = !full.
REQ-012 SHALL reflect a pushed entry at the FIFO head no earlier than the cycle after push.
REQ-013 SHALL not accept a push when full, even in the same cycle as a pop.
REQ-014 RST0: ctl=1 when FIFO non-empty, then go to IDLE; else ctl=0, stay.
REQ-015 IDLE: ctl=1 when FIFO non-empty and response register empty (or drained this cycle), then go to LDA; else ctl=0, stay.
REQ-016 LDA: ctl=1, bus_oe=1, bus_out=head.a, then go to LDB.
REQ-017 LDB: ctl=1, bus_oe=1, bus_out=head.b, then go to LDM.
REQ-018 LDM: ctl=1, bus_oe=1, bus_out={3'b000,head.op}, then go to LDC.
REQ-019 LDC: ctl=0, bus_oe=0 (ALU drives bus), then go to CAP.
REQ-020 CAP: ctl=0, bus_oe=0; register res_in/z_in/cout_in into rsp_data/rsp_z/rsp_c; set rsp_valid next cycle; pop FIFO; go to IDLE.
REQ-021 SHALL drive bus_out=0 whenever bus_oe=0.
REQ-022 SHALL hold rsp_* stable while rsp_valid & !rsp_ready; clear rsp_valid on handshake.
REQ-023 Latency: push into empty FIFO in IDLE at cycle 0 -> rsp_valid high at cycle 7; from RST0 -> cycle 8.
REQ-024 Back-to-back commands with rsp_ready=1 SHALL sustain one result per 6 cycles.
REQ-025 SHALL never leave IDLE/RST0 except as stated; dbg_state SHALL equal the mirrored S-encoding.

Reset
REQ-026 On reset: state RST0, FIFO empty, cmd_ready=1, ctl=0, bus_oe=0, bus_out=0, rsp_valid=0, rsp_data=0, rsp_z=0, rsp_c=0, busy=0, dbg_state=0.
REQ-027 Reset mid-sequence SHALL abort: in-flight and queued commands discarded, no response produced.
REQ-028 reset SHALL be the same net that resets the downstream controller, keeping the mirror aligned.

Structure
REQ-029 SHALL place controller state encodings (S0..S5) and op encodings (ADD=0, SUB=1) in shared package alu_pkg.
REQ-030 SHALL implement the FIFO as sub-module cmd_fifo (parameter DEPTH, width 9).

Verification
REQ-031 Reset, push {add,3,4} -> ctl=1 for 5 cycles, bus 3,4,0 in LDA/LDB/LDM, rsp_data=7, z=0, c=0 at cycle 8.
REQ-032 Push {sub,5,5} from IDLE -> rsp_data=0, rsp_z=1 at cycle 7.
REQ-033 Push {add,15,1} -> rsp_data=0, rsp_z=1, rsp_c=1.
REQ-034 Push 3 commands back-to-back with depth 2 -> third stalls on cmd_ready=0 until first CAP pop; results in order.
REQ-035 Hold rsp_ready=0 with 2 queued -> state stays IDLE, first result held stable; release -> second result follows.
REQ-036 Assert reset during LDB -> all outputs at reset values next cycle, no rsp_valid; subsequent command completes correctly.
